// File: rtl/spi_write_ctrl.sv
// SPI mode-0 write sequencer: steers an external MSB-first PISO register through its op codes
// and generates SCLK and active-low chip select for one Width-bit transfer per start request.
module spi_write_ctrl #(
    parameter int Width  = 8,
    parameter int ClkDiv = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] op_o,
    output logic       sclk_o,
    output logic       cs_no
);

    localparam int DW = $clog2(ClkDiv) + 1;
    localparam int BW = $clog2(Width) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(ClkDiv - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(Width - 1);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_LOW  = 3'd2,
        S_HIGH = 3'd3,
        S_STOP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   div_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic            div_last;
    logic            bit_last;

    assign div_last = (div_cnt_q == DIV_LAST);
    assign bit_last = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: state_d = S_LOW;
            S_LOW:  if (div_last) state_d = S_HIGH;
            S_HIGH: begin
                if (div_last) state_d = bit_last ? S_STOP : S_LOW;
            end
            S_STOP: if (div_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // div_cnt paces every SCLK phase and the CS hold; bit_cnt advances at the end of each HIGH phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                end
                S_LOW, S_STOP: begin
                    div_cnt_q <= div_last ? '0 : div_cnt_q + DW'(1);
                end
                S_HIGH: begin
                    div_cnt_q <= div_last ? '0 : div_cnt_q + DW'(1);
                    if (div_last && !bit_last) bit_cnt_q <= bit_cnt_q + BW'(1);
                end
                default: begin
                    div_cnt_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b1;
        done_o = 1'b0;
        op_o   = OP_HOLD;
        sclk_o = 1'b0;
        cs_no  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                cs_no  = 1'b1;
            end
            S_LOAD: op_o = OP_LOAD;
            S_LOW:  op_o = OP_HOLD;
            S_HIGH: begin
                sclk_o = 1'b1;
                // Shift on the last HIGH cycle so the next bit appears as SCLK falls.
                if (div_last && !bit_last) op_o = OP_SHIFT;
            end
            S_STOP: op_o = OP_HOLD;
            S_DONE: begin
                done_o = 1'b1;
                cs_no  = 1'b1;
                op_o   = OP_CLEAR;
            end
            default: begin
                busy_o = 1'b0;
                cs_no  = 1'b1;
            end
        endcase
    end

endmodule
